// File: rtl/alu_issue_queue.sv
// alu_issue_queue: collapsing oldest-ready-first issue queue for the ALU, with tag wakeup.
// Define ALU_IQ_SELF_WAKE_EN to let an issuing µop wake its dependents in the same cycle.
module alu_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 128,
    parameter int NWAKE     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic [TAG_W-1:0]           in_src1_tag,
    input  logic                       in_src1_rdy,
    input  logic [TAG_W-1:0]           in_src2_tag,
    input  logic                       in_src2_rdy,
    input  logic                       in_dest_we,
    input  logic [TAG_W-1:0]           in_dest_tag,
    input  logic [NWAKE-1:0]           wake_valid,
    input  logic [NWAKE*TAG_W-1:0]     wake_tag,
    output logic                       issue_valid,
    input  logic                       issue_allowin,
    output logic [PAYLOAD_W-1:0]       issue_payload,
    output logic                       issue_dest_we,
    output logic [TAG_W-1:0]           issue_dest_tag,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic [DEPTH-1:0]     r_v, r_r1, r_r2, r_we;
    logic [PAYLOAD_W-1:0] r_pl [DEPTH];
    logic [TAG_W-1:0]     r_t1 [DEPTH];
    logic [TAG_W-1:0]     r_t2 [DEPTH];
    logic [TAG_W-1:0]     r_dt [DEPTH];
    logic [OW-1:0]        r_occ;
    logic                 r_in_ready;

    logic [DEPTH-1:0]     w_n_v, w_n_r1, w_n_r2, w_n_we, w_rdy;
    logic [PAYLOAD_W-1:0] w_n_pl [DEPTH];
    logic [TAG_W-1:0]     w_n_t1 [DEPTH];
    logic [TAG_W-1:0]     w_n_t2 [DEPTH];
    logic [TAG_W-1:0]     w_n_dt [DEPTH];
    logic [SW-1:0]        w_sel;
    logic                 w_iss, w_enq, w_self_v;
    logic [TAG_W-1:0]     w_self_tag;
    logic [OW-1:0]        w_pos, w_n_occ;

    assign w_rdy = r_v & r_r1 & r_r2;

    always_comb begin
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (w_rdy[i]) w_sel = SW'(i);
    end

    assign issue_valid    = |w_rdy;
    assign issue_payload  = issue_valid ? r_pl[w_sel] : '0;
    assign issue_dest_we  = issue_valid & r_we[w_sel];
    assign issue_dest_tag = issue_valid ? r_dt[w_sel] : '0;
    assign in_ready       = r_in_ready;
    assign occupancy      = r_occ;

    assign w_iss   = issue_valid & issue_allowin;
    assign w_enq   = in_valid & r_in_ready;
    assign w_pos   = r_occ - OW'(w_iss);
    assign w_n_occ = r_occ + OW'(w_enq) - OW'(w_iss);

`ifdef ALU_IQ_SELF_WAKE_EN
    assign w_self_v   = w_iss & issue_dest_we;
    assign w_self_tag = issue_dest_tag;
`else
    assign w_self_v   = 1'b0;
    assign w_self_tag = '0;
`endif

    function automatic logic f_hit(input logic [TAG_W-1:0] t);
        logic h;
        h = w_self_v && (t == w_self_tag);
        for (int k = 0; k < NWAKE; k++)
            h = h | (wake_valid[k] && (wake_tag[k*TAG_W +: TAG_W] == t));
        return h;
    endfunction

    // Slots at or above the issued entry pull from the next slot up; the top slot empties.
    function automatic int f_src(input int i);
        return (w_iss && i >= int'(w_sel) && i < DEPTH - 1) ? i + 1 : i;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_n_v[i]  = r_v[f_src(i)] & ~(w_iss & (i == DEPTH - 1));
            w_n_pl[i] = r_pl[f_src(i)];
            w_n_t1[i] = r_t1[f_src(i)];
            w_n_t2[i] = r_t2[f_src(i)];
            w_n_dt[i] = r_dt[f_src(i)];
            w_n_we[i] = r_we[f_src(i)];
            w_n_r1[i] = r_r1[f_src(i)] | f_hit(r_t1[f_src(i)]);
            w_n_r2[i] = r_r2[f_src(i)] | f_hit(r_t2[f_src(i)]);
            if (w_enq && i == int'(w_pos)) begin
                w_n_v[i]  = 1'b1;
                w_n_pl[i] = in_payload;
                w_n_t1[i] = in_src1_tag;
                w_n_t2[i] = in_src2_tag;
                w_n_dt[i] = in_dest_tag;
                w_n_we[i] = in_dest_we;
                w_n_r1[i] = in_src1_rdy | f_hit(in_src1_tag);
                w_n_r2[i] = in_src2_rdy | f_hit(in_src2_tag);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_v        <= '0;
            r_occ      <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_v        <= w_n_v;
            r_occ      <= w_n_occ;
            r_in_ready <= w_n_occ < FULL;
        end
    end

    // Payload and tag fields need no reset: nothing reads them unless the slot is valid.
    always_ff @(posedge clk) begin
        r_pl <= w_n_pl;
        r_t1 <= w_n_t1;
        r_t2 <= w_n_t2;
        r_dt <= w_n_dt;
        r_we <= w_n_we;
        r_r1 <= w_n_r1;
        r_r2 <= w_n_r2;
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed and random stimulus against an age-ordered queue model;
// a negedge monitor checks per-cycle status and every issued µop from scoreboard queues.
module tb_alu_issue_queue;
    localparam int DEPTH = 4, TAG_W = 6, PW = 128, NWAKE = 3;
`ifdef ALU_IQ_SELF_WAKE_EN
    localparam bit SELF = 1'b1;
`else
    localparam bit SELF = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [PW-1:0] in_payload = '0, issue_payload;
    logic [TAG_W-1:0] in_src1_tag = '0, in_src2_tag = '0, in_dest_tag = '0, issue_dest_tag;
    logic in_src1_rdy = 1'b0, in_src2_rdy = 1'b0, in_dest_we = 1'b0, issue_dest_we;
    logic [NWAKE-1:0] wake_valid = '0;
    logic [NWAKE*TAG_W-1:0] wake_tag = '0;
    logic issue_valid, issue_allowin = 1'b0;
    logic [2:0] occupancy;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW), .NWAKE(NWAKE)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .in_src1_tag(in_src1_tag), .in_src1_rdy(in_src1_rdy),
        .in_src2_tag(in_src2_tag), .in_src2_rdy(in_src2_rdy), .in_dest_we(in_dest_we),
        .in_dest_tag(in_dest_tag), .wake_valid(wake_valid), .wake_tag(wake_tag),
        .issue_valid(issue_valid), .issue_allowin(issue_allowin), .issue_payload(issue_payload),
        .issue_dest_we(issue_dest_we), .issue_dest_tag(issue_dest_tag), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0]    pl;
        logic [TAG_W-1:0] t1, t2, dt;
        logic             r1, r2, we;
    } ent_t;
    typedef struct {
        logic       iv;
        logic [2:0] occ;
        logic       rdy;
    } st_t;
    typedef struct {
        logic [PW-1:0]    pl;
        logic             we;
        logic [TAG_W-1:0] dt;
    } iss_t;

    ent_t mq[$];
    st_t  sq[$];
    iss_t iq[$];
    int total = 0, bad = 0;

    function automatic bit hit(input logic [TAG_W-1:0] t, input logic [NWAKE-1:0] wv,
                               input logic [NWAKE*TAG_W-1:0] wt, input bit sv,
                               input logic [TAG_W-1:0] st);
        if (sv && t == st) return 1'b1;
        for (int k = 0; k < NWAKE; k++)
            if (wv[k] && wt[k*TAG_W +: TAG_W] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic ent_t mk(input logic [PW-1:0] pl, input logic [TAG_W-1:0] t1, input bit r1,
                                input logic [TAG_W-1:0] t2, input bit r2, input bit we,
                                input logic [TAG_W-1:0] dt);
        ent_t e;
        e.pl = pl; e.t1 = t1; e.r1 = r1; e.t2 = t2; e.r2 = r2; e.we = we; e.dt = dt;
        return e;
    endfunction

    // One clock of stimulus: record what the DUT must show now, drive, then advance the model.
    task automatic step(input bit inv, input ent_t e, input logic [NWAKE-1:0] wv,
                        input logic [NWAKE*TAG_W-1:0] wt, input bit allow, input bit fl, input bit rs);
        int idx;
        bit fire, enq, sv;
        logic [TAG_W-1:0] st;
        idx = -1;
        for (int i = 0; i < mq.size(); i++)
            if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
        sq.push_back('{idx >= 0, 3'(mq.size()), mq.size() < DEPTH});
        fire = (idx >= 0) && allow;
        enq  = inv && mq.size() < DEPTH;
        sv = 1'b0;
        st = '0;
        if (fire) begin
            iq.push_back('{mq[idx].pl, mq[idx].we, mq[idx].dt});
            sv = SELF && mq[idx].we;
            st = mq[idx].dt;
        end
        in_valid = inv; in_payload = e.pl; in_src1_tag = e.t1; in_src1_rdy = e.r1;
        in_src2_tag = e.t2; in_src2_rdy = e.r2; in_dest_we = e.we; in_dest_tag = e.dt;
        wake_valid = wv; wake_tag = wt; issue_allowin = allow; flush = fl; reset = rs;
        if (rs || fl) mq.delete();
        else begin
            if (fire) mq.delete(idx);
            foreach (mq[i]) begin
                if (hit(mq[i].t1, wv, wt, sv, st)) mq[i].r1 = 1'b1;
                if (hit(mq[i].t2, wv, wt, sv, st)) mq[i].r2 = 1'b1;
            end
            if (enq) begin
                e.r1 = e.r1 | hit(e.t1, wv, wt, sv, st);
                e.r2 = e.r2 | hit(e.t2, wv, wt, sv, st);
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit allow);
        for (int i = 0; i < n; i++) step(1'b0, mk('0, '0, 1'b0, '0, 1'b0, 1'b0, '0), '0, '0, allow, 1'b0, 1'b0);
    endtask

    task automatic rnd_step(input int fl_pct, input int rs_pct);
        ent_t e;
        logic [NWAKE-1:0] wv;
        logic [NWAKE*TAG_W-1:0] wt;
        e.pl = {$urandom, $urandom, $urandom, $urandom};
        e.t1 = TAG_W'($urandom_range(0, 7)); e.r1 = 1'($urandom_range(0, 1));
        e.t2 = TAG_W'($urandom_range(0, 7)); e.r2 = 1'($urandom_range(0, 1));
        e.dt = TAG_W'($urandom_range(0, 7)); e.we = 1'($urandom_range(0, 1));
        for (int k = 0; k < NWAKE; k++) begin
            wv[k] = $urandom_range(0, 3) == 0;
            wt[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
        end
        step($urandom_range(0, 99) < 60, e, wv, wt, $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < fl_pct, $urandom_range(0, 99) < rs_pct);
    endtask

    always @(negedge clk) begin
        if (sq.size() > 0) begin
            st_t s;
            s = sq.pop_front();
            total++;
            if (issue_valid !== s.iv) begin bad++; $display("FAIL issue_valid got=%0b exp=%0b t=%0t", issue_valid, s.iv, $time); end
            total++;
            if (occupancy !== s.occ) begin bad++; $display("FAIL occupancy got=%0d exp=%0d t=%0t", occupancy, s.occ, $time); end
            total++;
            if (in_ready !== s.rdy) begin bad++; $display("FAIL in_ready got=%0b exp=%0b t=%0t", in_ready, s.rdy, $time); end
            if (!issue_valid) begin
                total++;
                if (issue_payload !== '0 || issue_dest_we !== 1'b0 || issue_dest_tag !== '0) begin
                    bad++;
                    $display("FAIL idle_outputs got pl=%h we=%b tag=%h exp zero t=%0t", issue_payload, issue_dest_we, issue_dest_tag, $time);
                end
            end else if (issue_allowin) begin
                total++;
                if (iq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_issue got pl=%h exp none t=%0t", issue_payload, $time);
                end else begin
                    iss_t x;
                    x = iq.pop_front();
                    if (issue_payload !== x.pl || issue_dest_we !== x.we || issue_dest_tag !== x.dt) begin
                        bad++;
                        $display("FAIL issue got pl=%h we=%b tag=%h exp pl=%h we=%b tag=%h t=%0t",
                                 issue_payload, issue_dest_we, issue_dest_tag, x.pl, x.we, x.dt, $time);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // three ready µops drain in order
        for (int i = 1; i <= 3; i++) step(1'b1, mk(PW'(i), 6'h1, 1'b1, 6'h2, 1'b1, 1'b1, TAG_W'(i)), '0, '0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        // fill with issue blocked, then one issue
        for (int i = 1; i <= 4; i++) step(1'b1, mk(PW'(16 + i), 6'h1, 1'b1, 6'h2, 1'b1, 1'b0, 6'h0), '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(PW'(99), 6'h1, 1'b1, 6'h2, 1'b1, 1'b0, 6'h0), '0, '0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        idle(4, 1'b1);
        // older entry blocked on 0x12 lets the younger one go first
        step(1'b1, mk(PW'(32), 6'h12, 1'b0, 6'h2, 1'b1, 1'b0, 6'h0), '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(PW'(33), 6'h1, 1'b1, 6'h2, 1'b1, 1'b0, 6'h0), '0, '0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        step(1'b0, mk('0, '0, 1'b0, '0, 1'b0, 1'b0, '0), 3'b010, {6'h0, 6'h12, 6'h0}, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        // wake captured on the enqueue cycle
        step(1'b1, mk(PW'(48), 6'h1, 1'b1, 6'h05, 1'b0, 1'b0, 6'h0), 3'b100, {6'h05, 6'h0, 6'h0}, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        // producer/consumer through dest 0x20
        step(1'b1, mk(PW'(64), 6'h1, 1'b1, 6'h2, 1'b1, 1'b1, 6'h20), '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(PW'(65), 6'h20, 1'b0, 6'h2, 1'b1, 1'b0, 6'h0), '0, '0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1);
        step(1'b0, mk('0, '0, 1'b0, '0, 1'b0, 1'b0, '0), 3'b001, {6'h0, 6'h0, 6'h20}, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        // flush drops the queue and the same-cycle enqueue
        for (int i = 0; i < 3; i++) step(1'b1, mk(PW'(80 + i), 6'h1, 1'b1, 6'h2, 1'b1, 1'b0, 6'h0), '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(PW'(90), 6'h1, 1'b1, 6'h2, 1'b1, 1'b0, 6'h0), '0, '0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        for (int i = 0; i < 2000; i++) rnd_step(2, 1);
        idle(8, 1'b1);
        total++;
        if (iq.size() != 0) begin bad++; $display("FAIL missing_issues got=0 exp=%0d", iq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Scheduler that sits in front of the single-cycle ALU execute stage.
- Buffers up to DEPTH renamed ALU µops, tracks source-operand readiness by physical-tag wakeup, and selects the oldest ready entry to issue.
- Drives the ALU's valid/allowin handshake; the µop payload is opaque to this block.

Parameters:
DEPTH, 4, number of queue entries (2..16)
TAG_W, 6, physical register tag width
PAYLOAD_W, 128, opaque µop payload width (decoded inst, rob_entry_num, source values/ids)
NWAKE, 3, number of external wakeup broadcast ports

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  pipeline flush; clears queue
in_valid  in  1  dispatch offers a µop
in_ready  out  1  queue accepts; registered, high iff occupancy < DEPTH
in_payload  in  PAYLOAD_W  µop payload
in_src1_tag  in  TAG_W  source 1 physical tag
in_src1_rdy  in  1  source 1 already available
in_src2_tag  in  TAG_W  source 2 physical tag
in_src2_rdy  in  1  source 2 already available
in_dest_we  in  1  µop writes a register
in_dest_tag  in  TAG_W  destination physical tag
wake_valid  in  NWAKE  per-port wakeup strobe
wake_tag  in  NWAKE*TAG_W  per-port woken tag, port k at bits [k*TAG_W +: TAG_W]
issue_valid  out  1  an entry is selected for the ALU
issue_allowin  in  1  ALU can accept this cycle
issue_payload  out  PAYLOAD_W  payload of the selected entry (zero when issue_valid=0)
issue_dest_we  out  1  dest_we of the selected entry
issue_dest_tag  out  TAG_W  dest_tag of the selected entry
occupancy  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Storage: collapsing queue with entry 0 oldest. Each entry holds valid, payload, src1/src2 tag+ready, dest_we, dest_tag.
- Enqueue fires on in_valid & in_ready.
  - The new entry goes to slot occupancy, or slot occupancy-1 if an issue fires in the same cycle.
- Select: issue_valid = OR over entries of valid & src1_ready & src2_ready.
  - The lowest-index ready entry is selected.
  - Outputs are combinational from registered state only; there is no in_* → issue_* path.
- Issue fires on issue_valid & issue_allowin.
  - The selected entry is removed; all younger entries shift down one slot next cycle, preserving order.
  - If issue_allowin=0, issue_valid and the selection hold, and the selection may change only toward an older entry that became ready.
- Wakeup: a src that is not ready and whose tag equals any wake_tag[k] with wake_valid[k] becomes ready next cycle.
  - A woken entry is issuable at the earliest one cycle after the wake.
  - Wakeup applies to entries that are shifting in the same cycle.
  - Wakeup also applies to the µop being enqueued: an in_src tag matching a wake this cycle is captured as ready.
- Occupancy: next = occupancy + enq − iss. Simultaneous enqueue and issue when full is impossible because in_ready=0 when full; in_ready is not bypassed by issue.
- Flush and reset: all entries are invalidated and occupancy=0 next cycle; flush overrides same-cycle enqueue and wakeup.
- Reset values: in_ready=1, issue_valid=0, issue_payload=0, issue_dest_we=0, issue_dest_tag=0, occupancy=0.
- Empty: issue_valid=0. Both src ready at enqueue: the entry is issuable the cycle after enqueue.

Optional Feature:
- Macro ALU_IQ_SELF_WAKE_EN.
- Defined: on an issue fire with issue_dest_we=1, issue_dest_tag is treated as an extra internal wake port in that same cycle. A dependent entry then issues back-to-back in the next cycle, matching the ALU's one-cycle bypass.
- Undefined: no internal wake; dependents rely on external wake_valid/wake_tag only.

Test Plan:
- Reset, then enqueue 3 µops with all src ready and issue_allowin=1 → issue in cycles 1, 2, 3 in enqueue order; occupancy returns to 0; in_ready stays 1.
- Fill 4 entries with issue_allowin=0 → in_ready=0 and occupancy=4. Raise issue_allowin for 1 cycle → entry 0 issues, occupancy=3, in_ready=1 next cycle.
- Entry A with src1 tag 0x12 not ready, younger entry B ready → B issues first. wake_valid[1]=1 with wake_tag 0x12 in cycle N → A has issue_valid in cycle N+1.
- Enqueue a µop with src2 tag 0x05 in the same cycle as wake tag 0x05 → the entry is ready and issues the next cycle.
- ALU_IQ_SELF_WAKE_EN defined: A (dest 0x20) issues in cycle N, B (src1 0x20) issues in cycle N+1. Undefined: B waits for an external wake of 0x20.
- Queue holds 3 entries, flush asserted together with in_valid → occupancy=0, issue_valid=0 next cycle; the flushed enqueue is dropped.
